// File: rtl/sram_img_pkg.sv
// Shared state encoding, RGB565 field layout and frame defaults for the
// SRAM image-sampling blocks.
package sram_img_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam int unsigned RGB_R_W   = 5;
  localparam int unsigned RGB_G_W   = 6;
  localparam int unsigned RGB_B_W   = 5;
  localparam int unsigned RGB_R_OFF = 11;
  localparam int unsigned RGB_G_OFF = 5;
  localparam int unsigned RGB_B_OFF = 0;

  localparam int unsigned DEF_FRAME_W = 320;
  localparam int unsigned DEF_FRAME_H = 240;

  // Product with an elaboration-time constant, expanded as shift-and-add.
  function automatic logic [31:0] mul_const(input logic [31:0] v, input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 32; b++)
      if (k[b]) acc = acc + (v << b);
    return acc;
  endfunction

endpackage

// File: rtl/rgb565_avg4.sv
// Combinational per-channel mean of four RGB565 pixels (truncating).
module rgb565_avg4
  import sram_img_pkg::*;
(
  input  logic [15:0] p0,
  input  logic [15:0] p1,
  input  logic [15:0] p2,
  input  logic [15:0] p3,
  output logic [15:0] avg
);

  logic [RGB_R_W+1:0] r_sum;
  logic [RGB_G_W+1:0] g_sum;
  logic [RGB_B_W+1:0] b_sum;

  always_comb begin
    r_sum = (RGB_R_W+2)'(p0[RGB_R_OFF +: RGB_R_W]) + (RGB_R_W+2)'(p1[RGB_R_OFF +: RGB_R_W])
          + (RGB_R_W+2)'(p2[RGB_R_OFF +: RGB_R_W]) + (RGB_R_W+2)'(p3[RGB_R_OFF +: RGB_R_W]);
    g_sum = (RGB_G_W+2)'(p0[RGB_G_OFF +: RGB_G_W]) + (RGB_G_W+2)'(p1[RGB_G_OFF +: RGB_G_W])
          + (RGB_G_W+2)'(p2[RGB_G_OFF +: RGB_G_W]) + (RGB_G_W+2)'(p3[RGB_G_OFF +: RGB_G_W]);
    b_sum = (RGB_B_W+2)'(p0[RGB_B_OFF +: RGB_B_W]) + (RGB_B_W+2)'(p1[RGB_B_OFF +: RGB_B_W])
          + (RGB_B_W+2)'(p2[RGB_B_OFF +: RGB_B_W]) + (RGB_B_W+2)'(p3[RGB_B_OFF +: RGB_B_W]);
    avg   = {r_sum[RGB_R_W+1:2], g_sum[RGB_G_W+1:2], b_sum[RGB_B_W+1:2]};
  end

endmodule

// File: rtl/sram_grid_sampler.sv
// Reads a GRID_N x GRID_N lattice of pixels from a frame in SRAM and presents
// them row-major over a valid/ready port. SRAM_GRID_AVG_EN: 2x2 RGB565 mean per point.
module sram_grid_sampler
  import sram_img_pkg::*;
#(
  parameter int unsigned FRAME_W = DEF_FRAME_W,
  parameter int unsigned FRAME_H = DEF_FRAME_H,
  parameter int unsigned GRID_N  = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned RD_LAT  = 1,
  localparam int unsigned IDX_W  = (GRID_N * GRID_N > 1) ? $clog2(GRID_N * GRID_N) : 1
) (
  input  logic              wclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        origin_x,
  input  logic [9:0]        origin_y,
  input  logic [9:0]        pitch_x,
  input  logic [9:0]        pitch_y,
  output logic              sram_sel,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [DATA_W-1:0] sample_data,
  output logic [IDX_W-1:0]  sample_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = (GRID_N > 1) ? $clog2(GRID_N) : 1;
`ifdef SRAM_GRID_AVG_EN
  localparam int unsigned FOOT = 1;
`else
  localparam int unsigned FOOT = 0;
`endif

  state_t              state, state_nxt;
  logic [9:0]          org_x, org_y, pit_x, pit_y;
  logic [ADDR_W-1:0]   row_base, row_step, pt_addr, sub_off;
  logic [CNT_W-1:0]    col_i, row_j;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   sample_q;
  logic [1:0]          wait_cnt;
  logic [31:0]         max_x, max_y;
  logic                cfg_bad, last_col, last_row, wait_end, sub_last;

  // Extent check is done wide so that any pitch/origin overflow is rejected.
  always_comb begin
    max_x    = 32'(org_x) + mul_const(32'(pit_x), GRID_N - 1) + FOOT;
    max_y    = 32'(org_y) + mul_const(32'(pit_y), GRID_N - 1) + FOOT;
    cfg_bad  = (max_x >= FRAME_W) || (max_y >= FRAME_H);
    last_col = (col_i == CNT_W'(GRID_N - 1));
    last_row = (row_j == CNT_W'(GRID_N - 1));
    wait_end = (32'(wait_cnt) == RD_LAT - 2);
  end

`ifdef SRAM_GRID_AVG_EN
  logic [1:0]  sub_q;
  logic [15:0] pix0, pix1, pix2, avg_pix;

  assign sub_last = (sub_q == 2'd3);

  always_comb begin
    case (sub_q)
      2'd0:    sub_off = '0;
      2'd1:    sub_off = ADDR_W'(1);
      2'd2:    sub_off = ADDR_W'(FRAME_W);
      default: sub_off = ADDR_W'(FRAME_W + 1);
    endcase
  end

  rgb565_avg4 u_avg (
    .p0  (pix0),
    .p1  (pix1),
    .p2  (pix2),
    .p3  (sram_rdata[15:0]),
    .avg (avg_pix)
  );
`else
  assign sub_last = 1'b1;
  assign sub_off  = '0;
`endif

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sram_sel     = 1'b0;
    sram_rd      = 1'b0;
    sram_addr    = '0;
    sample_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    sample_data  = sample_q;
    sample_idx   = idx_q;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CHECK;
      S_CHECK: begin
        err       = cfg_bad;
        state_nxt = cfg_bad ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        busy      = 1'b1;
        sram_sel  = 1'b1;
        sram_rd   = 1'b1;
        sram_addr = pt_addr + sub_off;
        state_nxt = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_end) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy      = 1'b1;
        state_nxt = sub_last ? S_PRESENT : S_ISSUE;
      end
      S_PRESENT: begin
        busy         = 1'b1;
        sample_valid = 1'b1;
        if (sample_ready) state_nxt = (last_col && last_row) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Addresses advance by addition only: column step pitch_x, row step pitch_y*FRAME_W.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      org_x    <= '0;
      org_y    <= '0;
      pit_x    <= '0;
      pit_y    <= '0;
      row_base <= '0;
      row_step <= '0;
      pt_addr  <= '0;
      col_i    <= '0;
      row_j    <= '0;
      idx_q    <= '0;
      sample_q <= '0;
      wait_cnt <= '0;
`ifdef SRAM_GRID_AVG_EN
      sub_q    <= '0;
      pix0     <= '0;
      pix1     <= '0;
      pix2     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          org_x <= origin_x;
          org_y <= origin_y;
          pit_x <= pitch_x;
          pit_y <= pitch_y;
        end
        S_CHECK: if (!cfg_bad) begin
          row_base <= ADDR_W'(mul_const(32'(org_y), FRAME_W));
          pt_addr  <= ADDR_W'(mul_const(32'(org_y), FRAME_W) + 32'(org_x));
          row_step <= ADDR_W'(mul_const(32'(pit_y), FRAME_W));
          col_i    <= '0;
          row_j    <= '0;
          idx_q    <= '0;
`ifdef SRAM_GRID_AVG_EN
          sub_q    <= '0;
`endif
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + 2'd1;
        S_CAPTURE: begin
`ifdef SRAM_GRID_AVG_EN
          case (sub_q)
            2'd0:    pix0 <= sram_rdata[15:0];
            2'd1:    pix1 <= sram_rdata[15:0];
            2'd2:    pix2 <= sram_rdata[15:0];
            default: ;
          endcase
          if (sub_last) begin
            sample_q <= DATA_W'(avg_pix);
            sub_q    <= '0;
          end else begin
            sub_q    <= sub_q + 2'd1;
          end
`else
          sample_q <= sram_rdata;
`endif
        end
        S_PRESENT: if (sample_ready && !(last_col && last_row)) begin
          idx_q <= idx_q + IDX_W'(1);
          if (last_col) begin
            col_i    <= '0;
            row_j    <= row_j + CNT_W'(1);
            row_base <= row_base + row_step;
            pt_addr  <= row_base + row_step + ADDR_W'(org_x);
          end else begin
            col_i    <= col_i + CNT_W'(1);
            pt_addr  <= pt_addr + ADDR_W'(pit_x);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_grid_sampler.md
SRAM_GRID_SAMPLER -- requirements
Module: sram_grid_sampler

Interface
REQ-001 Parameters: FRAME_W 320 frame width px; FRAME_H 240 frame height px; GRID_N 3 grid points per axis; DATA_W 16 pixel word; ADDR_W 19 SRAM address; RD_LAT 1 read latency, cycles from strobe to valid rdata (1..4).
REQ-002 wclk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle pulse, begin one grid pass.
REQ-005 origin_x, origin_y  in  10  first grid point; pitch_x, pitch_y  in  10  grid spacing; all latched on accepted start.
REQ-006 sram_sel, sram_rd  out  1  SRAM chip select and read strobe; sram_addr  out  ADDR_W; sram_rdata  in  DATA_W.
REQ-007 sample_valid  out  1; sample_ready  in  1; sample_data  out  DATA_W; sample_idx  out  clog2(GRID_N*GRID_N), row-major point index.
REQ-008 busy  out  1  pass in progress; done  out  1  one-cycle pass-complete pulse; err  out  1  one-cycle rejected-start pulse.

Function
REQ-009 Point (i,j), i column, j row, 0..GRID_N-1: x=origin_x+i*pitch_x, y=origin_y+j*pitch_y, address y*FRAME_W+x; points visited row-major, idx=j*GRID_N+i.
REQ-010 Only grid-point addresses are read; no full-frame scan.
REQ-011 Address generation incremental (row base += pitch_y*FRAME_W, column += pitch_x); no runtime multiplier.
REQ-012 States: IDLE, CHECK, ISSUE, WAIT, CAPTURE, PRESENT, DONE.
REQ-013 IDLE: start -> CHECK; start ignored in every other state.
REQ-014 CHECK (1 cycle): max x >= FRAME_W or max y >= FRAME_H (including +1 footprint when averaging) -> err=1 for one cycle, back to IDLE, no SRAM access; else -> ISSUE.
REQ-015 ISSUE: sram_sel=sram_rd=1 exactly one cycle with sram_addr valid; -> WAIT.
REQ-016 WAIT: RD_LAT-1 cycles, strobes low; CAPTURE registers sram_rdata in the cycle RD_LAT after the strobe.
REQ-017 PRESENT: sample_valid=1; sample_data, sample_idx stable until sample_valid&&sample_ready.
REQ-018 On handshake: next point -> ISSUE next cycle; last point -> DONE.
REQ-019 DONE: done=1 one cycle, busy drops same cycle, -> IDLE.
REQ-020 busy=1 from CHECK acceptance through DONE exclusive.
REQ-021 sample_ready held low stalls indefinitely; no SRAM activity while stalled.
REQ-022 Minimum per point, ready high: 2+RD_LAT cycles.
REQ-023 Coordinate arithmetic 11 bits, no wrap; overflow caught by CHECK.

Reset
REQ-024 rst_n low: immediately, asynchronously, all outputs 0 (sram_addr, sample_data, sample_idx included), state IDLE, latched config cleared.
REQ-025 Reset mid-pass aborts with no done/err; first start after release runs a full pass.

Configuration
REQ-026 Macro SRAM_GRID_AVG_EN defined: each point reads (x,y),(x+1,y),(x,y+1),(x+1,y+1) as four ISSUE/WAIT/CAPTURE rounds; sample_data = per-channel RGB565 mean (R5,G6,B5 sums, >>2 truncating).
REQ-027 Macro undefined: single read per point, sample_data = raw sram_rdata; no accumulator logic synthesised.

Structure
REQ-028 Shared package sram_img_pkg: state enum, RGB565 field widths/offsets, default FRAME_W/FRAME_H.
REQ-029 One sub-module rgb565_avg4 (combinational 4-pixel mean), instantiated only under SRAM_GRID_AVG_EN.

Verification
REQ-030 Defaults, origin 40/40, pitch 80/80, ready=1 -> addrs 12840,12920,13000,38440,38520,38600,64040,64120,64200, idx 0..8, done one cycle after last handshake.
REQ-031 ready held low 10 cycles at idx 4 -> sample_data/idx frozen, no sram_rd pulses, resumes on ready.
REQ-032 origin_x 300, pitch_x 80 -> err one cycle, busy never 1, no sram_sel.
REQ-033 AVG_EN, footprint 0xFFFF,0x0000,0xFFFF,0x0000 -> sample_data 0x7BEF.
REQ-034 rst_n low at idx 5 -> outputs 0 at once, no done; restart gives full 9 samples.
REQ-035 RD_LAT=3, memory model returns addr[15:0] -> each sample_data equals its own address, second start during busy ignored.
